// File: rtl/ring_pkg.sv
// Shared types and helpers for one-hot ring counter producers and consumers.
package ring_pkg;

    localparam int unsigned MAX_N = 64;

    typedef enum logic [1:0] {HUNT, TRACK, LOCKED} mon_state_t;

    function automatic logic is_onehot(input logic [MAX_N-1:0] vector);
        return $countones(vector) == 1;
    endfunction

    // Wrapping step of a ring position: dir=0 moves up, dir=1 moves down.
    function automatic int unsigned next_idx(input int unsigned idx, input logic dir,
                                             input int unsigned n);
        if (dir)
            return (idx + n - 1) % n;
        else
            return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/ring_counter_monitor_onehot_to_index.sv
// Combinational one-hot decoder: reports the set-bit position and whether exactly one bit is set.
module onehot_to_index
    import ring_pkg::*;
#(
    parameter int unsigned N = 4,
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     ring_in,
    output logic [IDX_W-1:0] idx,
    output logic             legal
);

    assign legal = is_onehot(MAX_N'(ring_in));

    // Highest set bit wins; the result only matters when legal is high.
    always_comb begin
        idx = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (ring_in[i])
                idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/ring_counter_monitor.sv
// Ring counter monitor: decodes a one-hot ring vector, tracks its advance and reports lock and errors.
module ring_counter_monitor
    import ring_pkg::*;
#(
    parameter int unsigned N         = 4,
    parameter int unsigned LOCK_CNT  = 2,
    parameter int unsigned ERR_CNT_W = 8,
    localparam int unsigned IDX_W    = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [N-1:0]         ring_in,
    input  logic                 dir,
    input  logic                 clear_cnt,
    output logic [IDX_W-1:0]     idx,
    output logic                 idx_valid,
    output logic                 locked,
    output logic                 onehot_err,
    output logic                 seq_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int unsigned CNT_W = $clog2(LOCK_CNT + 1);

    mon_state_t           state_reg;
    logic [CNT_W-1:0]     match_reg;
    logic [IDX_W-1:0]     idx_reg;
    logic                 idx_valid_reg;
    logic                 locked_reg;
    logic                 onehot_err_reg;
    logic                 seq_err_reg;
    logic [ERR_CNT_W-1:0] err_count_reg;

    logic [IDX_W-1:0] dec_idx;
    logic             dec_legal;
    logic [IDX_W-1:0] exp_idx;
    logic             idx_match;
    logic             lock_reached;
    logic             onehot_event;
    logic             seq_event;

    onehot_to_index #(.N(N)) u_decode (
        .ring_in (ring_in),
        .idx     (dec_idx),
        .legal   (dec_legal)
    );

    assign exp_idx      = IDX_W'(next_idx(32'(idx_reg), dir, N));
    assign idx_match    = (dec_idx == exp_idx);
    assign lock_reached = (32'(match_reg) + 32'd1) >= LOCK_CNT;
    assign onehot_event = en & ~dec_legal;
    assign seq_event    = en & dec_legal & (state_reg == LOCKED) & ~idx_match;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= HUNT;
            match_reg      <= '0;
            idx_reg        <= '0;
            idx_valid_reg  <= 1'b0;
            locked_reg     <= 1'b0;
            onehot_err_reg <= 1'b0;
            seq_err_reg    <= 1'b0;
            err_count_reg  <= '0;
        end else begin
            onehot_err_reg <= onehot_event;
            seq_err_reg    <= seq_event;

            // Clear wins over a same-cycle error; the pulse itself is unaffected.
            if (clear_cnt)
                err_count_reg <= '0;
            else if ((onehot_event | seq_event) && (err_count_reg != '1))
                err_count_reg <= err_count_reg + 1'b1;

            if (en) begin
                idx_valid_reg <= dec_legal;
                if (!dec_legal) begin
                    state_reg  <= HUNT;
                    match_reg  <= '0;
                    locked_reg <= 1'b0;
                end else begin
                    idx_reg <= dec_idx;
                    case (state_reg)
                        HUNT: begin
                            state_reg <= TRACK;
                            match_reg <= '0;
                        end
                        TRACK: begin
                            if (idx_match) begin
                                match_reg <= match_reg + 1'b1;
                                if (lock_reached) begin
                                    state_reg  <= LOCKED;
                                    locked_reg <= 1'b1;
                                end
                            end else begin
                                match_reg <= '0;
                            end
                        end
                        LOCKED: begin
                            if (!idx_match) begin
                                state_reg  <= TRACK;
                                match_reg  <= '0;
                                locked_reg <= 1'b0;
                            end
                        end
                        default: state_reg <= HUNT;
                    endcase
                end
            end
        end
    end

    assign idx        = idx_reg;
    assign idx_valid  = idx_valid_reg;
    assign locked     = locked_reg;
    assign onehot_err = onehot_err_reg;
    assign seq_err    = seq_err_reg;
    assign err_count  = err_count_reg;

endmodule

// File: tb/tb_ring_counter_monitor.sv
// Self-checking bench for ring_counter_monitor against a streak-based reference model.
module tb_ring_counter_monitor;

    localparam int N = 4;
    localparam int LOCK_CNT = 2;
    localparam int ERR_CNT_W = 2;
    localparam int CNT_MAX = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic [3:0] ring_in = 4'b0;
    logic       dir = 1'b0;
    logic       clear_cnt = 1'b0;
    logic [1:0] idx;
    logic       idx_valid;
    logic       locked;
    logic       onehot_err;
    logic       seq_err;
    logic [1:0] err_count;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: last legal position, run of correct advances since it.
    logic [1:0] m_idx;
    logic       m_valid, m_locked, m_oh, m_seq;
    int         m_cnt;
    bit         have_seed;
    int         seed_idx;
    int         streak;

    wire  [7:0] act_v = {idx, idx_valid, locked, onehot_err, seq_err, err_count};
    logic [7:0] exp_v;

    ring_counter_monitor #(.N(N), .LOCK_CNT(LOCK_CNT), .ERR_CNT_W(ERR_CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .ring_in    (ring_in),
        .dir        (dir),
        .clear_cnt  (clear_cnt),
        .idx        (idx),
        .idx_valid  (idx_valid),
        .locked     (locked),
        .onehot_err (onehot_err),
        .seq_err    (seq_err),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_idx = 0; m_valid = 0; m_locked = 0; m_oh = 0; m_seq = 0; m_cnt = 0;
        have_seed = 0; seed_idx = 0; streak = 0;
        exp_v = {m_idx, m_valid, m_locked, m_oh, m_seq, 2'(m_cnt)};
    endtask

    task automatic model_step(input bit e, input logic [3:0] r, input bit d, input bit c);
        int pos;
        int want;
        m_oh = 0;
        m_seq = 0;
        if (e) begin
            if ($countones(r) != 1) begin
                m_oh = 1; m_valid = 0; have_seed = 0; streak = 0;
            end else begin
                pos = 0;
                for (int i = 0; i < N; i++) if (r[i]) pos = i;
                m_valid = 1;
                m_idx = 2'(pos);
                want = d ? (seed_idx + N - 1) % N : (seed_idx + 1) % N;
                if (!have_seed) begin
                    have_seed = 1; streak = 0;
                end else if (pos == want) begin
                    if (streak < LOCK_CNT) streak++;
                end else begin
                    m_seq = (streak >= LOCK_CNT);
                    streak = 0;
                end
                seed_idx = pos;
            end
        end
        m_locked = (streak >= LOCK_CNT);
        if (c) m_cnt = 0;
        else if ((m_oh || m_seq) && m_cnt < CNT_MAX) m_cnt++;
        exp_v = {m_idx, m_valid, m_locked, m_oh, m_seq, 2'(m_cnt)};
    endtask

    task automatic apply(input bit e, input logic [3:0] r, input bit d, input bit c);
        en = e; ring_in = r; dir = d; clear_cnt = c;
        @(posedge clk);
        model_step(e, r, d, c);
        #1;
    endtask

    // Called at posedge+1: asserts reset mid-cycle and releases on the falling edge.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        model_reset();
        #2 rst_n = 1'b1;
        en = 0; clear_cnt = 0;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        model_reset();
        #2;
        n_cmp++;
        if (act_v !== 8'b0) begin
            n_bad++; $display("FAIL reset: got %b want %b", act_v, 8'b0);
        end
        #5 rst_n = 1'b1;
    endtask

    task automatic test_lock();
        logic [3:0] seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int i = 0; i < 5; i++) begin
            apply(1, seq[i], 0, 0);
            n_cmp++;
            if (act_v !== exp_v) begin
                n_bad++; $display("FAIL lock[%0d]: got %b want %b", i, act_v, exp_v);
            end
        end
        n_cmp++;
        if ({locked, idx, idx_valid} !== 4'b1001) begin
            n_bad++; $display("FAIL lock_wrap: got locked/idx/valid %b want 1001", {locked, idx, idx_valid});
        end
        $display("test_lock done: locked=%0b idx=%0d", locked, idx);
    endtask

    task automatic test_seq_err();
        logic [3:0] seq [3] = '{4'b0100, 4'b1000, 4'b0001};
        do_reset();
        apply(1, 4'b0001, 0, 0); apply(1, 4'b0010, 0, 0); apply(1, 4'b0100, 0, 0);
        apply(1, 4'b1000, 0, 0); apply(1, 4'b0001, 0, 0);
        for (int i = 0; i < 3; i++) begin
            apply(1, seq[i], 0, 0);
            n_cmp++;
            if (act_v !== exp_v) begin
                n_bad++; $display("FAIL seq_err[%0d]: got %b want %b", i, act_v, exp_v);
            end
            if (i == 0) begin
                n_cmp++;
                if ({seq_err, err_count, locked, idx} !== 6'b1_01_0_10) begin
                    n_bad++; $display("FAIL seq_err_pulse: got %b want 101010", {seq_err, err_count, locked, idx});
                end
            end
        end
        n_cmp++;
        if (locked !== 1'b1) begin
            n_bad++; $display("FAIL seq_relock: got %b want 1", locked);
        end
        $display("test_seq_err done: err_count=%0d locked=%0b", err_count, locked);
    endtask

    task automatic test_illegal();
        do_reset();
        apply(1, 4'b0001, 0, 0); apply(1, 4'b0010, 0, 0); apply(1, 4'b0100, 0, 0);
        apply(1, 4'b0011, 0, 0);
        n_cmp++;
        if (act_v !== exp_v || act_v !== 8'b10_0_0_10_01) begin
            n_bad++; $display("FAIL illegal_0011: got %b want %b", act_v, exp_v);
        end
        apply(1, 4'b0000, 0, 0);
        n_cmp++;
        if (act_v !== exp_v || err_count !== 2'd2) begin
            n_bad++; $display("FAIL illegal_0000: got %b want %b", act_v, exp_v);
        end
        // HUNT must not judge the next sample as an advance.
        apply(1, 4'b1000, 0, 0);
        n_cmp++;
        if (act_v !== exp_v || locked !== 1'b0) begin
            n_bad++; $display("FAIL illegal_hunt: got %b want %b", act_v, exp_v);
        end
        $display("test_illegal done: err_count=%0d", err_count);
    endtask

    task automatic test_dir_gaps();
        logic [3:0] seq [3] = '{4'b1000, 4'b0100, 4'b0010};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            apply(1, seq[i], 1, 0);
            n_cmp++;
            if (act_v !== exp_v) begin
                n_bad++; $display("FAIL dir_sample[%0d]: got %b want %b", i, act_v, exp_v);
            end
            for (int g = 0; g < 2; g++) begin
                apply(0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 0);
                n_cmp++;
                if (act_v !== exp_v) begin
                    n_bad++; $display("FAIL dir_gap[%0d.%0d]: got %b want %b", i, g, act_v, exp_v);
                end
            end
        end
        n_cmp++;
        if ({locked, idx} !== 3'b101) begin
            n_bad++; $display("FAIL dir_lock: got %b want 101", {locked, idx});
        end
        $display("test_dir_gaps done: locked=%0b idx=%0d", locked, idx);
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            apply(1, 4'b0000, 0, 0);
            n_cmp++;
            if (act_v !== exp_v) begin
                n_bad++; $display("FAIL sat[%0d]: got %b want %b", i, act_v, exp_v);
            end
        end
        n_cmp++;
        if (err_count !== 2'd3) begin
            n_bad++; $display("FAIL sat_cap: got %0d want 3", err_count);
        end
        apply(1, 4'b0011, 0, 1);
        n_cmp++;
        if ({onehot_err, err_count} !== 3'b100 || act_v !== exp_v) begin
            n_bad++; $display("FAIL clear_err: got %b want %b", act_v, exp_v);
        end
        $display("test_saturation done: err_count=%0d", err_count);
    endtask

    task automatic test_async_reset();
        do_reset();
        apply(1, 4'b0001, 0, 0); apply(1, 4'b0010, 0, 0); apply(1, 4'b0100, 0, 0);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (act_v !== 8'b0) begin
            n_bad++; $display("FAIL async_reset: got %b want %b", act_v, 8'b0);
        end
        #1 rst_n = 1'b1;
        apply(1, 4'b1000, 0, 0);
        n_cmp++;
        if (act_v !== exp_v || locked !== 1'b0) begin
            n_bad++; $display("FAIL post_reset_hunt: got %b want %b", act_v, exp_v);
        end
        apply(1, 4'b0001, 0, 0); apply(1, 4'b0010, 0, 0);
        n_cmp++;
        if (act_v !== exp_v || locked !== 1'b1) begin
            n_bad++; $display("FAIL post_reset_lock: got %b want %b", act_v, exp_v);
        end
        $display("test_async_reset done: locked=%0b", locked);
    endtask

    task automatic test_random();
        bit         e, d, c;
        int         sel, k;
        logic [3:0] r;
        int         bad_before;
        d = 0;
        bad_before = n_bad;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            e = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) d = ~d;
            c = ($urandom_range(0, 24) == 0);
            sel = $urandom_range(0, 9);
            if (sel < 6) begin
                k = have_seed ? (d ? (seed_idx + N - 1) % N : (seed_idx + 1) % N)
                              : $urandom_range(0, 3);
                r = 4'(1 << k);
            end else if (sel < 8) begin
                r = 4'(1 << $urandom_range(0, 3));
            end else begin
                r = 4'($urandom_range(0, 15));
            end
            apply(e, r, d, c);
            n_cmp++;
            if (act_v !== exp_v) begin
                n_bad++; $display("FAIL random[%0d]: en=%0b ring=%b dir=%0b clr=%0b got %b want %b",
                                  i, e, r, d, c, act_v, exp_v);
            end
        end
        $display("test_random done: %0d new mismatches", n_bad - bad_before);
    endtask

    initial begin
        test_reset();
        test_lock();
        test_seq_err();
        test_illegal();
        test_dir_gaps();
        test_saturation();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
